// File: rtl/bnn_ocr_pkg.sv
// bnn_ocr_pkg: shared image geometry, buffer states and controller/buffer status codes
package bnn_ocr_pkg;
  localparam int IMG_BYTES = 113;
  localparam int IMG_ADDR_W = 7;
  typedef enum logic [1:0] {S_SWEEP, S_FILL, S_FULL} buf_state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;
endpackage

// File: rtl/image_buffer_ram.sv
// image_buffer_ram: simple dual-port RAM, one write port and one registered read port
module image_buffer_ram #(
  parameter int DEPTH = 113,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  // addresses past the image read as zero rather than whatever the array holds
  always_comb rdata_d = !re ? rdata_q : ({1'b0, raddr} < (ADDR_W+1)'(DEPTH)) ? mem[raddr] : '0;
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else rdata_q <= rdata_d;
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/image_buffer.sv
// image_buffer: handshaken sequential image store with zeroing sweep and registered read port
module image_buffer
  import bnn_ocr_pkg::*;
#(
  parameter int IMG_BYTES = bnn_ocr_pkg::IMG_BYTES,
  parameter int ADDR_W = bnn_ocr_pkg::IMG_ADDR_W,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              buffer_write_request,
  input  logic [DATA_W-1:0] buffer_write_data,
  output logic              buffer_write_ready,
  output logic              write_ack,
  input  logic              clear,
  output logic              buffer_full,
  output logic              buffer_empty,
  output logic [ADDR_W:0]   wr_count,
  input  logic              bnn_rd_en,
  input  logic [ADDR_W-1:0] bnn_rd_addr,
  output logic [DATA_W-1:0] bnn_rd_data,
  output logic              bnn_rd_valid
);
  buf_state_t state_q, state_d;
  logic [ADDR_W-1:0] sweep_ptr_q, sweep_ptr_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic clear_q, ack_q, ack_d, full_q, full_d, empty_q, empty_d, rd_valid_q;
  logic clear_rise, accept, sweeping, ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  // only a rising clear restarts the sweep; a held clear just blocks writes
  always_comb begin
    sweeping = state_q == S_SWEEP;
    clear_rise = clear && !clear_q;
    buffer_write_ready = state_q == S_FILL && !clear && !ack_q;
    accept = buffer_write_request && buffer_write_ready;
    state_d = clear_rise ? S_SWEEP
            : (sweeping && sweep_ptr_q == ADDR_W'(IMG_BYTES - 1)) ? S_FILL
            : (accept && wr_ptr_q == (ADDR_W+1)'(IMG_BYTES - 1)) ? S_FULL
            : state_q;
    sweep_ptr_d = clear_rise ? '0 : sweeping ? sweep_ptr_q + 1'b1 : sweep_ptr_q;
    wr_ptr_d = clear_rise ? '0 : accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    ack_d = accept;
    full_d = state_d == S_FULL;
    empty_d = state_q == S_FILL && state_d == S_FILL && wr_ptr_d == '0;
    ram_we = sweeping || accept;
    ram_waddr = sweeping ? sweep_ptr_q : wr_ptr_q[ADDR_W-1:0];
    ram_wdata = sweeping ? '0 : buffer_write_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SWEEP;
      sweep_ptr_q <= '0;
      wr_ptr_q <= '0;
      clear_q <= 1'b0;
      ack_q <= 1'b0;
      full_q <= 1'b0;
      empty_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_ptr_q <= sweep_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      clear_q <= clear;
      ack_q <= ack_d;
      full_q <= full_d;
      empty_q <= empty_d;
      rd_valid_q <= bnn_rd_en;
    end
  end
  image_buffer_ram #(.DEPTH(IMG_BYTES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk(clk),
    .rst_n(rst_n),
    .we(ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re(bnn_rd_en),
    .raddr(bnn_rd_addr),
    .rdata(bnn_rd_data)
  );
  assign write_ack = ack_q;
  assign buffer_full = full_q;
  assign buffer_empty = empty_q;
  assign wr_count = wr_ptr_q;
  assign bnn_rd_valid = rd_valid_q;
endmodule
